// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx byte stream.
// Packet lock (grant held until EOP byte or timeout): UART_TX_ARB_PKT_LOCK_EN.

module uart_tx_arb #(
  parameter int            N   = 4,
  parameter int            DW  = 8,
  parameter logic [DW-1:0] EOP = 'h0a,
  parameter int            TO  = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_tvalid,
  input  logic [N*DW-1:0] req_tdata,
  output logic [N-1:0]    req_tready,
  output logic            str_tvalid,
  output logic [DW-1:0]   str_tdata,
  input  logic            str_tready,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || N > 16) begin : g_bad_n
    $error("uart_tx_arb: N must be 1..16");
  end
  if (TO < 1) begin : g_bad_to
    $error("uart_tx_arb: TO must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [N-1:0]  grant_q, grant_d;

  logic          any_req;
  logic          found;
  logic [PW-1:0] sel;
  logic          g_valid;
  logic [DW-1:0] g_data;
  logic          xfer;
  logic          rel_ev;

  // pick first requester after ptr, wrapping modulo N
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_tvalid[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  assign any_req = |req_tvalid;
  assign g_valid = req_tvalid[gidx_q];
  assign g_data  = req_tdata[int'(gidx_q)*DW +: DW];
  assign xfer    = (state_q == BUSY) && g_valid && str_tready;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  localparam int CW = $clog2(TO + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          eop_hit;
  logic          tmo;

  assign eop_hit = xfer && (g_data == EOP);
  assign tmo     = !g_valid && (cnt_q == CW'(TO - 1));
  assign rel_ev  = (state_q == BUSY) && (eop_hit || tmo);

  // idle counter: consecutive BUSY cycles with granted port not valid
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && !g_valid && !rel_ev) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // idle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign rel_ev = (state_q == BUSY) && (xfer || !g_valid);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // grant, grant index and rotation pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= PW'(N - 1);
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
    end
  end

  // next state: arbitrate in IDLE, hold grant in BUSY until release
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (any_req) begin
          state_d = BUSY;
          gidx_d  = sel;
          for (int i = 0; i < N; i++) begin
            grant_d[i] = (PW'(i) == sel);
          end
        end
      end
      (state_q == BUSY): begin
        if (rel_ev) begin
          state_d = IDLE;
          ptr_d   = gidx_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs: quiet in IDLE, pass-through of granted port in BUSY
  always_comb begin
    str_tvalid = 1'b0;
    str_tdata  = '0;
    req_tready = '0;
    busy       = 1'b0;
    grant      = grant_q;
    if (state_q == BUSY) begin
      busy       = 1'b1;
      str_tvalid = g_valid;
      str_tdata  = g_data;
      req_tready = grant_q & {N{str_tready}};
    end
  end

endmodule
